// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among
// pChNum producer channels, granting bursts of up to pBurstLen words.
//
// Build option: define FIFO_ARB_BURST_EN to honour pBurstLen; when it is not
// defined every grant is a single word and the burst counter is not built.
//
// Ports:
//   iCLK    FIFO write clock
//   iRST    synchronous active-high reset
//   iChWd   channel write data, channel k at [k*pFifoBitWidth +: pFifoBitWidth]
//   iChReq  channel k holds a valid word
//   oChAck  one-hot pulse, channel word consumed this cycle
//   oWd     FIFO write data
//   oWe     FIFO write enable (combinational from iFull/iChReq/iRST)
//   iFull   FIFO full flag
//   oGrant  index of the granted channel
//   oBusy   a burst is in progress
module fifo_write_arbiter #(
  parameter int unsigned pChNum        = 4,
  parameter int unsigned pFifoBitWidth = 8,
  parameter int unsigned pBurstLen     = 4
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic [pChNum*pFifoBitWidth-1:0]   iChWd,
  input  logic [pChNum-1:0]                 iChReq,
  output logic [pChNum-1:0]                 oChAck,
  output logic [pFifoBitWidth-1:0]          oWd,
  output logic                              oWe,
  input  logic                              iFull,
  output logic [$clog2(pChNum)-1:0]         oGrant,
  output logic                              oBusy
);

  localparam int unsigned IW = $clog2(pChNum);

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BURST_LEN = pBurstLen;
  localparam int unsigned CW        = $clog2(pBurstLen + 1);
`else
  // pBurstLen is ignored: every grant is exactly one word
  localparam int unsigned BURST_LEN = (pBurstLen >= 1) ? 1 : 1;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                    state, state_n;
  logic [IW-1:0]             sel, sel_n;
  logic [IW-1:0]             last, last_n;
  logic [pFifoBitWidth-1:0]  ch_wd [pChNum];
  logic                      rr_hit;
  logic [IW-1:0]             rr_idx;
  int                        cand;
  logic                      wr_en;

`ifdef FIFO_ARB_BURST_EN
  logic [CW-1:0]             cnt, cnt_n, cnt_inc;
  assign cnt_inc = cnt + CW'(1);
`endif

  // Unpack flat channel data bus
  always_comb begin
    for (int k = 0; k < int'(pChNum); k++) begin
      ch_wd[k] = iChWd[k*pFifoBitWidth +: pFifoBitWidth];
    end
  end

  // Round-robin search starting one past the last winner, explicit modulo wrap
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int i = 1; i <= int'(pChNum); i++) begin
      cand = (int'(last) + i) % int'(pChNum);
      if (!rr_hit && iChReq[IW'(cand)]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(cand);
      end
    end
  end

  // Write is gated by full and reset in the same cycle
  assign wr_en  = (state == BURST) && iChReq[sel] && !iFull && !iRST;
  assign oWe    = wr_en;
  assign oWd    = ch_wd[sel];
  assign oGrant = sel;
  assign oBusy  = (state == BURST);

  always_comb begin
    oChAck      = '0;
    oChAck[sel] = wr_en;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
`ifdef FIFO_ARB_BURST_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (rr_hit) begin
          sel_n   = rr_idx;
          last_n  = rr_idx;
          state_n = BURST;
`ifdef FIFO_ARB_BURST_EN
          cnt_n   = '0;
`endif
        end
      end
      BURST: begin
        // A dropped request releases the grant; full simply holds everything
        if (!iChReq[sel]) begin
          state_n = IDLE;
        end else if (wr_en) begin
`ifdef FIFO_ARB_BURST_EN
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(BURST_LEN)) state_n = IDLE;
`else
          if (BURST_LEN == 1) state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset gives channel 0 top priority
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      sel   <= '0;
      last  <= IW'(pChNum - 1);
`ifdef FIFO_ARB_BURST_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      sel   <= sel_n;
      last  <= last_n;
`ifdef FIFO_ARB_BURST_EN
      cnt   <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: randomized producers, a
// transaction-level arbiter model, and a monitor comparing every cycle.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int EFF = BL;
`else
  localparam int EFF = 1;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [N*W-1:0]     ch_wd;
  logic [N-1:0]       ch_req;
  logic [N-1:0]       ch_ack;
  logic [W-1:0]       wd;
  logic               we;
  logic               full;
  logic [1:0]         grant;
  logic               busy;

  fifo_write_arbiter #(
    .pChNum(N), .pFifoBitWidth(W), .pBurstLen(BL)
  ) dut (
    .iCLK(clk), .iRST(rst), .iChWd(ch_wd), .iChReq(ch_req), .oChAck(ch_ack),
    .oWd(wd), .oWe(we), .iFull(full), .oGrant(grant), .oBusy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           busy;
    int           grant;
    bit           we;
    int           ch;
    logic [W-1:0] data;
  } exp_t;

  exp_t st_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_writes = 0;
  int   dut_writes = 0;

  // Producer state
  logic [N-1:0] preq;
  logic [W-1:0] pdata [N];
  int           idle [N];
  bit           acked [N];

  // Reference arbiter: who owns the port, words left in the grant, rotation base
  int m_owner = -1;
  int m_left  = 0;
  int m_last  = N - 1;
  int m_grant = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, exp);
    end
  endtask

  // Monitor: compare DUT against the expected entry for this cycle
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      logic [31:0] ea;
      mon_e = st_q.pop_front();
      ea = mon_e.we ? (32'd1 << mon_e.ch) : 32'd0;
      chk("busy",  mon_e.cyc, 32'(busy),   32'(mon_e.busy));
      chk("grant", mon_e.cyc, 32'(grant),  32'(mon_e.grant));
      chk("we",    mon_e.cyc, 32'(we),     32'(mon_e.we));
      chk("ack",   mon_e.cyc, 32'(ch_ack), ea);
      if (mon_e.we) chk("wdata", mon_e.cyc, 32'(wd), 32'(mon_e.data));
      if (we === 1'b1) dut_writes++;
    end
  end

  task automatic step(input int phase, input bit force_rst);
    exp_t e;
    bit   r;
    bit   f;
    bit   found;
    // producers react to the model's acks of the previous cycle
    for (int k = 0; k < N; k++) begin
      if (acked[k]) begin
        acked[k] = 0;
        if (phase < 2 || $urandom_range(9) < 7) begin
          pdata[k] = W'($urandom);
        end else begin
          preq[k] = 1'b0;
          idle[k] = int'($urandom_range(5, 1));
        end
      end else if (!preq[k]) begin
        if (idle[k] > 0) idle[k]--;
        else if (phase != 0 || k == 2) begin
          preq[k]  = 1'b1;
          pdata[k] = W'($urandom);
        end
      end
    end
    f = (phase == 2) && ($urandom_range(3) == 0);
    r = force_rst || ((phase == 2) && ($urandom_range(199) == 0));
    rst    = r;
    full   = f;
    ch_req = preq;
    for (int k = 0; k < N; k++) ch_wd[k*W +: W] = pdata[k];

    e.cyc   = cyc;
    e.busy  = (m_owner >= 0);
    e.grant = m_grant;
    e.we    = 0;
    e.ch    = 0;
    e.data  = '0;
    if (r) begin
      m_owner = -1;
      m_left  = 0;
      m_last  = N - 1;
      m_grant = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (!found && preq[c]) begin
          found   = 1;
          m_owner = c;
          m_grant = c;
          m_last  = c;
          m_left  = EFF;
        end
      end
    end else if (!preq[m_owner]) begin
      m_owner = -1;
    end else if (!f) begin
      e.we   = 1;
      e.ch   = m_owner;
      e.data = pdata[m_owner];
      acked[m_owner] = 1;
      model_writes++;
      m_left--;
      if (m_left == 0) m_owner = -1;
    end
    st_q.push_back(e);
    cyc++;
  endtask

  initial begin
    rst    = 1'b1;
    full   = 1'b0;
    ch_req = '0;
    ch_wd  = '0;
    preq   = '0;
    for (int k = 0; k < N; k++) begin
      pdata[k] = '0;
      idle[k]  = 0;
      acked[k] = 0;
    end
    repeat (2) @(posedge clk);
    // reset-state cycle, then single channel, all channels, random traffic
    @(posedge clk); #1; step(0, 1'b1);
    for (int i = 0; i < 60; i++)   begin @(posedge clk); #1; step(0, 1'b0); end
    for (int i = 0; i < 100; i++)  begin @(posedge clk); #1; step(1, 1'b0); end
    for (int i = 0; i < 3000; i++) begin @(posedge clk); #1; step(2, 1'b0); end
    repeat (3) @(posedge clk);
    chk("drain",  cyc, 32'(st_q.size()), 32'd0);
    chk("writes", cyc, 32'(dut_writes), 32'(model_writes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of one FIFO among `pChNum` producer channels in the write-clock domain. Each winning channel gets a burst of up to `pBurstLen` words, with stalls driven by the FIFO full flag. The block sits directly in front of the FIFO write side (`iWd`/`iWe`/`oFull`), so several producers can feed one FIFO without their own muxing logic.

## Interface
- `pChNum`, 4: number of producer channels, 2..8.
- `pFifoBitWidth`, 8: FIFO word width.
- `pBurstLen`, 4: maximum words per grant, 1..256.
- `iCLK` in 1: FIFO write clock. Single clock; reset is synchronous and active-high.
- `iRST` in 1: synchronous active-high reset.
- `iChWd` in `pChNum*pFifoBitWidth`: channel write data, channel k at bits [k*W +: W].
- `iChReq` in `pChNum`: channel k holds a valid word.
- `oChAck` out `pChNum`: one-hot pulse, channel k word consumed this cycle.
- `oWd` out `pFifoBitWidth`: FIFO write data. Connect to FIFO `iWd`.
- `oWe` out 1: FIFO write enable. Connect to FIFO `iWe`.
- `iFull` in 1: FIFO full. Connect from FIFO `oFull`.
- `oGrant` out `clog2(pChNum)`: index of the granted channel.
- `oBusy` out 1: a burst is in progress.

## Operation
- Two-state FSM: IDLE and BURST.
- **IDLE**
  - Search `iChReq` round-robin, starting at `rLast+1` modulo `pChNum`.
  - The first set bit wins: register its index as `rSel` (`oGrant`) and as `rLast`.
  - Clear the burst counter and go to BURST.
  - If no request is set, stay in IDLE.
- **BURST**
  - `oWe = iChReq[rSel] & ~iFull & ~iRST`.
  - `oWd = iChWd[rSel]`.
  - `oChAck[rSel] = oWe`; all other ack bits are 0.
  - On each write, increment the counter.
  - Go to IDLE when the counter reaches `pBurstLen` on a write, or when `iChReq[rSel]` is 0. A dropped request releases the grant immediately.
- While `iFull` is high in BURST: hold the counter and state, keep `oWe` at 0, and keep the grant (no preemption).
- A channel must keep `iChReq` and its data stable until it sees `oChAck`. A new word is presented the cycle after an ack.
- `oBusy` is 1 exactly when the state is BURST.
- Counter width is `clog2(pBurstLen+1)`. Index arithmetic wraps modulo `pChNum`; a non-power-of-2 `pChNum` must wrap explicitly.

## Timing
- Reset values:
  - State IDLE, counter 0, `rSel` 0.
  - `rLast = pChNum-1`, so channel 0 has top priority after reset.
  - `oWe` 0, `oChAck` 0, `oBusy` 0, `oGrant` 0.
  - `oWd` equals channel 0 data and is don't-care while `oWe` is 0.
- Arbitration latency is one cycle. A request seen in IDLE at cycle N produces the first write at cycle N+1 if the FIFO is not full.
- An uninterrupted `pBurstLen` burst occupies `pBurstLen` cycles, followed by one IDLE arbitration cycle. With `pBurstLen`=4, throughput is 4/5.
- `iFull` is combinational to `oWe` in the same cycle, so no write is issued into a full FIFO.
- Reset during a burst: `oWe` and `oChAck` are forced to 0 in that cycle. On the next edge everything returns to reset values. No partial ack occurs.
- Simultaneous burst end and a new request: the request is served in the IDLE cycle that follows, never in the same cycle.

## Configuration
- `FIFO_ARB_BURST_EN`
  - Defined: burst behaviour as above, with `pBurstLen` honoured.
  - Undefined: `pBurstLen` is ignored and forced to 1. Each grant is a single word and the counter logic is removed. Throughput is 1/2 and channels are interleaved word by word.

## Test plan
- **Reset state:** after reset, `oWe`=0, `oBusy`=0, `oGrant`=0, `oChAck`=0.
- **Single channel:** `iChReq`=4'b0100, `pBurstLen`=4, `iFull`=0 → 4 writes on consecutive cycles with `oGrant`=2, then 1 IDLE cycle, then another 4-word burst.
- **Round-robin:** all four channels request continuously → grant order 0,1,2,3,0, with 4 words each and `oChAck` one-hot matching `oGrant`.
- **Full stall:** hold `iFull`=1 for 3 cycles mid-burst after word 2 → `oWe`=0 for those cycles, grant held, words 3 and 4 written after release, total 4 words.
- **Early release:** channel 1 drops `iChReq` after 2 words → back to IDLE, and the next requester after 1 wins.
- **Reset mid-burst and single-word mode:** assert `iRST` during word 2 → no write or ack that cycle, and channel 0 has priority afterwards. With `FIFO_ARB_BURST_EN` undefined, two channels requesting → alternating single writes 0,1,0,1 every 2 cycles.
